seq_detector_param: RTL and testbench



---
 rtl/seq_detector_param.sv | 154 +++++++++++++++
 tb/tb_seq_detector_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Serial bit-pattern detector with a runtime-programmable pattern (up to
//   PAT_W bits), overlap / non-overlap matching, input qualification and a
//   saturating match counter.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in           serial data bit
//   in_valid     qualifies in; a bit is accepted on an edge with in_valid=1
//   cfg_load     1-cycle strobe: latch cfg_* and flush the history
//   cfg_pattern  pattern; bit [len-1] is received first, bit [0] last
//   cfg_len      pattern length (0 -> 1, >PAT_W -> PAT_W)
//   cfg_overlap  1 = overlapping matches, 0 = flush history on a match
//   cnt_clr      synchronous clear of match_count (wins over an increment)
//   match        registered 1-cycle pulse, one clock after the accepting edge
//   match_count  saturating number of matches
//   fill         bits currently held toward a match (0..len)
module seq_detector_param #(
    parameter int unsigned         PAT_W       = 8,
    parameter int unsigned         CNT_W       = 8,
    parameter logic [PAT_W-1:0]    RST_PATTERN = 8'b0000_1011,
    parameter int unsigned         RST_LEN     = 4,
    parameter int unsigned         LEN_W       = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [LEN_W-1:0] fill
);

    typedef enum logic [0:0] {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] RST_LEN_V = LEN_W'(RST_LEN);
    // A length of 1 is armed straight away (fill 0 >= len-1).
    localparam state_t RST_STATE = (RST_LEN <= 1) ? ARMED : FILLING;

    state_t           state, state_nxt;
    logic [PAT_W-1:0] hist, hist_nxt;
    logic [PAT_W-1:0] pattern, pattern_nxt;
    logic [LEN_W-1:0] len, len_nxt;
    logic             overlap, overlap_nxt;
    logic [LEN_W-1:0] fill_nxt;
    logic             match_nxt;
    logic [CNT_W-1:0] count_nxt;

    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] shifted;
    logic             accept;
    logic             hit;
    logic [LEN_W-1:0] len_clamped;

    // ARMED once fill >= len-1; evaluated without subtraction to avoid underflow.
    function automatic state_t state_for(input logic [LEN_W-1:0] f,
                                         input logic [LEN_W-1:0] l);
        if (({1'b0, f} + (LEN_W+1)'(1)) >= {1'b0, l})
            return ARMED;
        else
            return FILLING;
    endfunction

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++)
            mask[i] = (i < 32'(len));
    end

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0)
            len_clamped = LEN_W'(1);
        else if (32'(cfg_len) > PAT_W)
            len_clamped = LEN_W'(PAT_W);
    end

    assign accept  = in_valid && !cfg_load;
    assign shifted = {hist[PAT_W-2:0], in};
    assign hit     = accept && (state == ARMED) && (((shifted ^ pattern) & mask) == '0);

    always_comb begin
        state_nxt   = state;
        hist_nxt    = hist;
        fill_nxt    = fill;
        pattern_nxt = pattern;
        len_nxt     = len;
        overlap_nxt = overlap;
        match_nxt   = 1'b0;
        count_nxt   = match_count;

        if (cfg_load) begin
            pattern_nxt = cfg_pattern;
            len_nxt     = len_clamped;
            overlap_nxt = cfg_overlap;
            hist_nxt    = '0;
            fill_nxt    = '0;
            state_nxt   = state_for('0, len_clamped);
        end else if (accept) begin
            hist_nxt = shifted;
            if (hit) begin
                match_nxt = 1'b1;
                if (overlap) begin
                    fill_nxt  = len;
                    state_nxt = ARMED;
                end else begin
                    hist_nxt  = '0;
                    fill_nxt  = '0;
                    state_nxt = state_for('0, len);
                end
            end else begin
                fill_nxt  = (fill < len) ? fill + LEN_W'(1) : len;
                state_nxt = state_for(fill_nxt, len);
            end
        end

        if (cnt_clr)
            count_nxt = '0;
        else if (hit && (match_count != '1))
            count_nxt = match_count + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RST_STATE;
            hist        <= '0;
            fill        <= '0;
            pattern     <= RST_PATTERN;
            len         <= RST_LEN_V;
            overlap     <= 1'b1;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            state       <= state_nxt;
            hist        <= hist_nxt;
            fill        <= fill_nxt;
            pattern     <= pattern_nxt;
            len         <= len_nxt;
            overlap     <= overlap_nxt;
            match       <= match_nxt;
            match_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param
//   Directed-vector bench for seq_detector_param (PAT_W=8, CNT_W=2) with
//   hand-computed expected values checked by immediate assertions.
module tb_seq_detector_param;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned LEN_W = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             in;
    logic             in_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic [LEN_W-1:0] fill;

    int total = 0;
    int bad   = 0;

    seq_detector_param #(
        .PAT_W       (PAT_W),
        .CNT_W       (CNT_W),
        .RST_PATTERN (8'b0000_1011),
        .RST_LEN     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_count (match_count),
        .fill        (fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        in       = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic ov);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        cfg_load    = 1'b1;
        tick();
        cfg_load    = 1'b0;
    endtask

    task automatic clear();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        in          = 1'b0;
        in_valid    = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        cnt_clr     = 1'b0;
        tick();
        tick();
        check("rst_match", 32'(match), 0);
        check("rst_count", 32'(match_count), 0);
        check("rst_fill",  32'(fill), 0);
        reset = 1'b0;
        tick();

        // Reset config 1011/4, overlap: stream 1,0,1,1,0,1,1
        send(1); check("ov_b1", 32'(match), 0);
        send(0); check("ov_b2", 32'(match), 0);
        send(1); check("ov_b3", 32'(match), 0);
        check("ov_fill3", 32'(fill), 3);
        send(1); check("ov_b4", 32'(match), 1);
        check("ov_fill4", 32'(fill), 4);
        send(0); check("ov_b5", 32'(match), 0);
        send(1); check("ov_b6", 32'(match), 0);
        send(1); check("ov_b7", 32'(match), 1);
        check("ov_count", 32'(match_count), 2);
        idle();  check("ov_pulse_end", 32'(match), 0);
        clear(); check("clr_count", 32'(match_count), 0);

        // Non-overlap 1011/4, same stream
        load(8'h0B, 4, 1'b0);
        check("nov_load_fill", 32'(fill), 0);
        send(1); send(0); send(1);
        send(1); check("nov_b4", 32'(match), 1);
        check("nov_fill_flush", 32'(fill), 0);
        send(0); check("nov_b5", 32'(match), 0);
        send(1); check("nov_b6", 32'(match), 0);
        send(1); check("nov_b7", 32'(match), 0);
        check("nov_fill_end", 32'(fill), 3);
        check("nov_count", 32'(match_count), 1);
        clear();

        // Pattern 11 len 2, overlap
        load(8'h03, 2, 1'b1);
        send(1); check("p11ov_b1", 32'(match), 0);
        send(1); check("p11ov_b2", 32'(match), 1);
        send(1); check("p11ov_b3", 32'(match), 1);
        send(1); check("p11ov_b4", 32'(match), 1);
        check("p11ov_count", 32'(match_count), 3);
        clear();

        // Pattern 11 len 2, non-overlap
        load(8'h03, 2, 1'b0);
        send(1); check("p11nov_b1", 32'(match), 0);
        send(1); check("p11nov_b2", 32'(match), 1);
        send(1); check("p11nov_b3", 32'(match), 0);
        send(1); check("p11nov_b4", 32'(match), 1);
        check("p11nov_count", 32'(match_count), 2);
        clear();

        // Bubbles between partial sequence bits
        load(8'h0B, 4, 1'b1);
        send(1); send(0);
        for (int i = 0; i < 5; i++) begin
            idle();
            check("bub_match", 32'(match), 0);
            check("bub_fill", 32'(fill), 2);
        end
        send(1); check("bub_b3", 32'(match), 0);
        send(1); check("bub_b4", 32'(match), 1);
        check("bub_count", 32'(match_count), 1);
        clear();

        // Saturation: pattern 1 len 1, six 1s, CNT_W=2
        load(8'h01, 1, 1'b1);
        send(1); check("sat_c1", 32'(match_count), 1);
        send(1); check("sat_c2", 32'(match_count), 2);
        send(1); check("sat_c3", 32'(match_count), 3);
        send(1); check("sat_c4", 32'(match_count), 3);
        send(1); check("sat_c5", 32'(match_count), 3);
        send(1); check("sat_c6", 32'(match_count), 3);
        check("sat_match", 32'(match), 1);
        // Clear coincident with a hit
        cnt_clr = 1'b1;
        send(1);
        cnt_clr = 1'b0;
        check("clr_hit_match", 32'(match), 1);
        check("clr_hit_count", 32'(match_count), 0);
        // Same-cycle bit during cfg_load is discarded
        in = 1'b1; in_valid = 1'b1;
        load(8'h01, 1, 1'b1);
        in_valid = 1'b0;
        check("load_discard_match", 32'(match), 0);
        check("load_discard_fill", 32'(fill), 0);
        check("load_keeps_count", 32'(match_count), 0);

        // cfg_len=0 stored as 1
        load(8'h01, 0, 1'b1);
        send(1); check("len0_hit", 32'(match), 1);
        check("len0_fill", 32'(fill), 1);
        send(0); check("len0_miss", 32'(match), 0);
        clear();

        // cfg_len=15 clamped to 8, pattern A6 = 1,0,1,0,0,1,1,0
        load(8'hA6, 15, 1'b1);
        send(1); send(0); send(1); send(0); send(0); send(1);
        send(1); check("len15_b7", 32'(match), 0);
        check("len15_fill7", 32'(fill), 7);
        send(0); check("len15_b8", 32'(match), 1);
        check("len15_fill8", 32'(fill), 8);

        // Config inputs without cfg_load are ignored
        cfg_pattern = 8'h00; cfg_len = 1; cfg_overlap = 1'b0;
        send(0); check("cfg_ignored", 32'(match), 0);
        check("cfg_ignored_fill", 32'(fill), 8);

        // Reset mid-stream (count is 1 here)
        send(1); send(0); send(1);
        reset = 1'b1;
        #1;
        check("mrst_fill", 32'(fill), 0);
        check("mrst_count", 32'(match_count), 0);
        check("mrst_match", 32'(match), 0);
        tick();
        reset = 1'b0;
        send(1); check("mrst_b1", 32'(match), 0);
        send(1); check("mrst_b2", 32'(match), 0);
        check("mrst_fill2", 32'(fill), 2);
        send(0); send(1);
        send(1); check("mrst_pat1011", 32'(match), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
